// File: rtl/decode_issue_stage.sv
// Decode/issue stage for RV32I reg-reg and reg-imm ALU instructions.
// Holds the integer register file, reads rs1/rs2 with write-back bypass,
// builds the second ALU operand, and presents a registered operand bundle
// to the execute stage under valid/ready flow control.
module decode_issue_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr_in,
  input  logic            instr_valid_in,
  output logic            instr_ready_out,
  input  logic            flush_in,
  input  logic            wb_en_in,
  input  logic [4:0]      wb_rd_in,
  input  logic [XLEN-1:0] wb_data_in,
  input  logic            ex_ready_in,
  output logic            valid_out,
  output logic [6:0]      opcode_out,
  output logic [2:0]      funct3_out,
  output logic [6:0]      funct7_out,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] rs1_value_out,
  output logic [XLEN-1:0] mux_result_out,
  output logic            illegal_out
);

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  // Register file; entry 0 is never written so x0 stays zero.
  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  // Operand bundle and status flops.
  logic            valid_q,      valid_d;
  logic            illegal_q,    illegal_d;
  logic [6:0]      opcode_q,     opcode_d;
  logic [2:0]      funct3_q,     funct3_d;
  logic [6:0]      funct7_q,     funct7_d;
  logic [4:0]      rd_q,         rd_d;
  logic [XLEN-1:0] rs1_value_q,  rs1_value_d;
  logic [XLEN-1:0] mux_result_q, mux_result_d;

  // Instruction fields.
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7_raw;

  assign opcode     = instr_in[6:0];
  assign rd         = instr_in[11:7];
  assign funct3     = instr_in[14:12];
  assign rs1        = instr_in[19:15];
  assign rs2        = instr_in[24:20];
  assign funct7_raw = instr_in[31:25];

  logic            wb_hit;
  logic            accept;
  logic            supported;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] op2_val;
  logic [6:0]      funct7_val;

  // A write to x0 is not a real write and must never be bypassed.
  assign wb_hit = wb_en_in && (wb_rd_in != 5'd0);

  assign instr_ready_out = !reset && (!valid_q || ex_ready_in);
  assign accept          = instr_valid_in && instr_ready_out && !flush_in;

  // Asynchronous rs1 read: x0 is zero, same-cycle write-back wins over the array.
  always_comb begin
    rs1_val = '0;
    if (rs1 == 5'd0) begin
      rs1_val = '0;
    end else if (wb_hit && (wb_rd_in == rs1)) begin
      rs1_val = wb_data_in;
    end else begin
      rs1_val = regs_q[rs1];
    end
  end

  // Asynchronous rs2 read with the same x0 and bypass rules as rs1.
  always_comb begin
    rs2_val = '0;
    if (rs2 == 5'd0) begin
      rs2_val = '0;
    end else if (wb_hit && (wb_rd_in == rs2)) begin
      rs2_val = wb_data_in;
    end else begin
      rs2_val = regs_q[rs2];
    end
  end

  // Opcode decode: choose rs2 or immediate as the second operand and the funct7 to forward.
  always_comb begin
    supported  = 1'b0;
    op2_val    = '0;
    funct7_val = 7'd0;
    case (opcode)
      OP_REG: begin
        supported  = 1'b1;
        op2_val    = rs2_val;
        funct7_val = funct7_raw;
      end
      OP_IMM: begin
        supported = 1'b1;
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          // Shifts: shamt is zero-extended and funct7 selects logical/arithmetic.
          op2_val    = {{(XLEN-5){1'b0}}, instr_in[24:20]};
          funct7_val = funct7_raw;
        end else begin
          op2_val    = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
          funct7_val = 7'd0;
        end
      end
      default: begin
        supported  = 1'b0;
        op2_val    = '0;
        funct7_val = 7'd0;
      end
    endcase
  end

  // Bundle next state: flush beats accept, accept beats drain, otherwise hold.
  always_comb begin
    valid_d      = valid_q;
    illegal_d    = 1'b0;
    opcode_d     = opcode_q;
    funct3_d     = funct3_q;
    funct7_d     = funct7_q;
    rd_d         = rd_q;
    rs1_value_d  = rs1_value_q;
    mux_result_d = mux_result_q;
    if (flush_in) begin
      valid_d = 1'b0;
    end else if (accept) begin
      if (supported) begin
        valid_d      = 1'b1;
        opcode_d     = opcode;
        funct3_d     = funct3;
        funct7_d     = funct7_val;
        rd_d         = rd;
        rs1_value_d  = rs1_val;
        mux_result_d = op2_val;
      end else begin
        // Unsupported opcode is swallowed; ready was high so any held bundle is gone too.
        valid_d   = 1'b0;
        illegal_d = 1'b1;
      end
    end else if (valid_q && ex_ready_in) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Register file next state: write-back lands here, x0 is never written.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wb_hit) begin
      regs_d[wb_rd_in] = wb_data_in;
    end else begin
      regs_d[0] = regs_q[0];
    end
  end

  // State registers with synchronous reset clearing the bundle and the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      illegal_q    <= 1'b0;
      opcode_q     <= 7'd0;
      funct3_q     <= 3'd0;
      funct7_q     <= 7'd0;
      rd_q         <= 5'd0;
      rs1_value_q  <= '0;
      mux_result_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      illegal_q    <= illegal_d;
      opcode_q     <= opcode_d;
      funct3_q     <= funct3_d;
      funct7_q     <= funct7_d;
      rd_q         <= rd_d;
      rs1_value_q  <= rs1_value_d;
      mux_result_q <= mux_result_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign valid_out      = valid_q;
  assign illegal_out    = illegal_q;
  assign opcode_out     = opcode_q;
  assign funct3_out     = funct3_q;
  assign funct7_out     = funct7_q;
  assign rd_out         = rd_q;
  assign rs1_value_out  = rs1_value_q;
  assign mux_result_out = mux_result_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed, table-driven bench for decode_issue_stage.
module tb_decode_issue_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instr_in;
  logic        instr_valid_in;
  logic        instr_ready_out;
  logic        flush_in;
  logic        wb_en_in;
  logic [4:0]  wb_rd_in;
  logic [31:0] wb_data_in;
  logic        ex_ready_in;
  logic        valid_out;
  logic [6:0]  opcode_out;
  logic [2:0]  funct3_out;
  logic [6:0]  funct7_out;
  logic [4:0]  rd_out;
  logic [31:0] rs1_value_out;
  logic [31:0] mux_result_out;
  logic        illegal_out;

  int checks;
  int errors;

  decode_issue_stage #(.XLEN(32), .NUM_REGS(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_in       (instr_in),
    .instr_valid_in (instr_valid_in),
    .instr_ready_out(instr_ready_out),
    .flush_in       (flush_in),
    .wb_en_in       (wb_en_in),
    .wb_rd_in       (wb_rd_in),
    .wb_data_in     (wb_data_in),
    .ex_ready_in    (ex_ready_in),
    .valid_out      (valid_out),
    .opcode_out     (opcode_out),
    .funct3_out     (funct3_out),
    .funct7_out     (funct7_out),
    .rd_out         (rd_out),
    .rs1_value_out  (rs1_value_out),
    .mux_result_out (mux_result_out),
    .illegal_out    (illegal_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        iv;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exr;
    logic        e_ready;
    logic        e_valid;
    logic        e_ill;
    logic        chk_b;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic [6:0]  e_f7;
    logic [4:0]  e_rd;
    logic [31:0] e_rs1;
    logic [31:0] e_mux;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [31:0] instr, input logic iv, input logic flush,
    input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_data,
    input logic exr, input logic e_ready, input logic e_valid, input logic e_ill,
    input logic chk_b, input logic [6:0] e_op, input logic [2:0] e_f3,
    input logic [6:0] e_f7, input logic [4:0] e_rd, input logic [31:0] e_rs1,
    input logic [31:0] e_mux);
    vec_t v;
    v.instr = instr; v.iv = iv; v.flush = flush; v.wb_en = wb_en;
    v.wb_rd = wb_rd; v.wb_data = wb_data; v.exr = exr; v.e_ready = e_ready;
    v.e_valid = e_valid; v.e_ill = e_ill; v.chk_b = chk_b; v.e_op = e_op;
    v.e_f3 = e_f3; v.e_f7 = e_f7; v.e_rd = e_rd; v.e_rs1 = e_rs1; v.e_mux = e_mux;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic iv, input logic flush,
                       input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_data,
                       input logic exr);
    instr_in = instr; instr_valid_in = iv; flush_in = flush;
    wb_en_in = wb_en; wb_rd_in = wb_rd; wb_data_in = wb_data; ex_ready_in = exr;
  endtask

  task automatic check_bundle(input int idx, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rd,
                              input logic [31:0] rs1v, input logic [31:0] mux);
    chk("opcode", idx, {25'd0, opcode_out}, {25'd0, op});
    chk("funct3", idx, {29'd0, funct3_out}, {29'd0, f3});
    chk("funct7", idx, {25'd0, funct7_out}, {25'd0, f7});
    chk("rd", idx, {27'd0, rd_out}, {27'd0, rd});
    chk("rs1_value", idx, rs1_value_out, rs1v);
    chk("mux_result", idx, mux_result_out, mux);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);

    // Table: one cycle per entry; ready checked before the edge, outputs after.
    vecs.push_back(mk(32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 5'd0,  32'h0,         32'h0));
    vecs.push_back(mk(32'h0002_8313, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h13, 3'd0, 7'h00, 5'd6,  32'h0,         32'h0));
    vecs.push_back(mk(32'h0000_0000, 1'b0, 1'b0, 1'b1, 5'd1,  32'h0000_0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 5'd0,  32'h0,         32'h0));
    vecs.push_back(mk(32'hFFC0_8113, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h13, 3'd0, 7'h00, 5'd2,  32'h0000_0010, 32'hFFFF_FFFC));
    vecs.push_back(mk(32'h0031_8233, 1'b1, 1'b0, 1'b1, 5'd3,  32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h33, 3'd0, 7'h00, 5'd4,  32'hDEAD_BEEF, 32'hDEAD_BEEF));
    vecs.push_back(mk(32'h0000_03B3, 1'b1, 1'b0, 1'b1, 5'd0,  32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h33, 3'd0, 7'h00, 5'd7,  32'h0,         32'h0));
    vecs.push_back(mk(32'h4030_D293, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h13, 3'd5, 7'h20, 5'd5,  32'h0000_0010, 32'h0000_0003));
    vecs.push_back(mk(32'h0000_0433, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h33, 3'd0, 7'h00, 5'd8,  32'h0,         32'h0));
    vecs.push_back(mk(32'h4011_84B3, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h33, 3'd0, 7'h20, 5'd9,  32'hDEAD_BEEF, 32'h0000_0010));
    vecs.push_back(mk(32'h01F0_9513, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h13, 3'd1, 7'h00, 5'd10, 32'h0000_0010, 32'h0000_001F));
    vecs.push_back(mk(32'hFFF0_C593, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h13, 3'd4, 7'h00, 5'd11, 32'h0000_0010, 32'hFFFF_FFFF));
    vecs.push_back(mk(32'h7FF1_F613, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h13, 3'd7, 7'h00, 5'd12, 32'hDEAD_BEEF, 32'h0000_07FF));
    // Back-pressure: new instruction offered for three cycles, held bundle must not move.
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(32'h0002_8313, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'h13, 3'd7, 7'h00, 5'd12, 32'hDEAD_BEEF, 32'h0000_07FF));
    end
    vecs.push_back(mk(32'h0002_8313, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h13, 3'd0, 7'h00, 5'd6,  32'h0,         32'h0));
    // Unsupported opcode: consumed, single-cycle illegal pulse.
    vecs.push_back(mk(32'h0000_2083, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 3'd0, 7'h00, 5'd0,  32'h0,         32'h0));
    vecs.push_back(mk(32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 5'd0,  32'h0,         32'h0));
    // Flush kills held bundle and drops the offered instruction; write-back still lands.
    vecs.push_back(mk(32'h0031_8233, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h33, 3'd0, 7'h00, 5'd4,  32'hDEAD_BEEF, 32'hDEAD_BEEF));
    vecs.push_back(mk(32'h0002_8313, 1'b1, 1'b1, 1'b1, 5'd13, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 5'd0,  32'h0,         32'h0));
    vecs.push_back(mk(32'h0000_2083, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 5'd0,  32'h0,         32'h0));
    vecs.push_back(mk(32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 5'd0,  32'h0,         32'h0));
    vecs.push_back(mk(32'h0006_8733, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h33, 3'd0, 7'h00, 5'd14, 32'hCAFE_F00D, 32'h0));
    // Bypass on rs2 only, then on rs1 of an I-type.
    vecs.push_back(mk(32'h00F0_8833, 1'b1, 1'b0, 1'b1, 5'd15, 32'h0000_ABCD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h33, 3'd0, 7'h00, 5'd16, 32'h0000_0010, 32'h0000_ABCD));
    vecs.push_back(mk(32'h0010_8893, 1'b1, 1'b0, 1'b1, 5'd1,  32'h0000_0077, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h13, 3'd0, 7'h00, 5'd17, 32'h0000_0077, 32'h0000_0001));
    vecs.push_back(mk(32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 5'd0,  32'h0,         32'h0));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", -1, {31'd0, instr_ready_out}, 32'd0);
    chk("reset_valid", -1, {31'd0, valid_out}, 32'd0);
    chk("reset_illegal", -1, {31'd0, illegal_out}, 32'd0);
    check_bundle(-1, 7'h00, 3'd0, 7'h00, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].iv, vecs[i].flush, vecs[i].wb_en,
            vecs[i].wb_rd, vecs[i].wb_data, vecs[i].exr);
      #1;
      chk("ready", i, {31'd0, instr_ready_out}, {31'd0, vecs[i].e_ready});
      @(posedge clk);
      #1;
      chk("valid", i, {31'd0, valid_out}, {31'd0, vecs[i].e_valid});
      chk("illegal", i, {31'd0, illegal_out}, {31'd0, vecs[i].e_ill});
      if (vecs[i].chk_b) begin
        check_bundle(i, vecs[i].e_op, vecs[i].e_f3, vecs[i].e_f7, vecs[i].e_rd,
                     vecs[i].e_rs1, vecs[i].e_mux);
      end
    end

    // Reset while a bundle is held: bundle discarded, regs cleared, wb/accept ignored.
    @(negedge clk);
    drive(32'h0010_8893, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_reset_valid", 100, {31'd0, valid_out}, 32'd1);
    chk("pre_reset_rs1", 100, rs1_value_out, 32'h0000_0077);
    @(negedge clk);
    reset = 1'b1;
    drive(32'h0002_8313, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0055, 1'b1);
    #1;
    chk("in_reset_ready", 101, {31'd0, instr_ready_out}, 32'd0);
    @(posedge clk);
    #1;
    chk("mid_reset_valid", 101, {31'd0, valid_out}, 32'd0);
    chk("mid_reset_illegal", 101, {31'd0, illegal_out}, 32'd0);
    check_bundle(101, 7'h00, 3'd0, 7'h00, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(32'h0010_8893, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    chk("post_reset_valid", 102, {31'd0, valid_out}, 32'd1);
    check_bundle(102, 7'h13, 3'd0, 7'h00, 5'd17, 32'h0, 32'h0000_0001);
    @(negedge clk);
    drive(32'h0052_8933, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    check_bundle(103, 7'h33, 3'd0, 7'h00, 5'd18, 32'h0, 32'h0);
    @(negedge clk);
    drive(32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    chk("final_drain_valid", 104, {31'd0, valid_out}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Producer side of the ALU operand interface.
- Accepts fetched 32-bit RV32I instructions over a valid/ready handshake.
- Holds the 32x32 integer register file, reads rs1/rs2, and generates I-type immediates.
- Selects the second operand and presents a registered operand bundle (opcode, funct3, funct7, rs1 value, mux result) to the execute-stage ALU with valid/ready flow control.

Parameters:
- XLEN, 32, datapath and register width
- NUM_REGS, 32, register file depth; x0 is hard-wired to zero

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- instr_in  input  32  instruction from fetch
- instr_valid_in  input  1  instr_in is valid
- instr_ready_out  output  1  stage accepts instr_in this cycle
- flush_in  input  1  kill held bundle and any incoming instruction
- wb_en_in  input  1  register file write enable
- wb_rd_in  input  5  write-back destination register
- wb_data_in  input  32  write-back data
- ex_ready_in  input  1  ALU stage consumes the bundle this cycle
- valid_out  output  1  operand bundle is valid
- opcode_out  output  7  instr[6:0]
- funct3_out  output  3  instr[14:12]
- funct7_out  output  7  instr[31:25] (forced 0 for non-shift immediates)
- rd_out  output  5  instr[11:7]
- rs1_value_out  output  32  register file value of rs1
- mux_result_out  output  32  rs2 value (R-type) or immediate (I-type)
- illegal_out  output  1  one-cycle pulse: accepted opcode not supported

Behaviour:
- Reset (reset=1 at a clk edge):
  - valid_out, illegal_out, and all bundle outputs go to 0.
  - All registers x1..x31 are cleared to 0.
  - wb writes and instruction accepts in that cycle are ignored.
  - Reset asserted mid-operation discards the held bundle.
- Ready: instr_ready_out = !reset && (!valid_out || ex_ready_in), combinational.
- Accept: an instruction is accepted when instr_valid_in && instr_ready_out && !flush_in. Its bundle is registered at that edge; latency is 1 cycle.
- Accept of a supported opcode:
  - valid_out=1 next cycle.
  - Bundle is stable while valid_out && !ex_ready_in.
- Drain: valid_out && ex_ready_in with no accept -> valid_out=0 next cycle. Back-to-back accept gives full throughput, 1 instr/cycle.
- Flush: flush_in=1 -> valid_out=0 next cycle and illegal_out=0.
  - Flush has priority over accept; the incoming instruction is dropped.
  - Write-back still occurs during a flush.
- Opcode 0110011 (reg-reg): mux_result_out = rs2 value; funct7_out = instr[31:25].
- Opcode 0010011 (immediate):
  - funct3 001/101: mux_result_out = zero-extended instr[24:20]; funct7_out = instr[31:25].
  - Other funct3: mux_result_out = sign-extended instr[31:20]; funct7_out = 0.
- Any other opcode:
  - The instruction is consumed.
  - valid_out=0 next cycle (the previously held bundle is consumed by definition, since ready was high).
  - illegal_out=1 for exactly one cycle.
- Register read: asynchronous; x0 reads as 0.
- Write-back:
  - When wb_en_in && wb_rd_in!=0, write wb_data_in at the clk edge.
  - Writes to x0 are ignored.
- Bypass: in the same cycle, if wb_en_in && wb_rd_in!=0 && wb_rd_in==rs1 (or rs2), the registered operand uses wb_data_in, not the stale array value.
- Widths: XLEN-bit values; no arithmetic is done here beyond extension.

Test Plan:
- Reset then idle -> valid_out=0, instr_ready_out=1, illegal_out=0. Reading x5 via an accepted addi yields rs1_value_out=0.
- Write x1=0x00000010 via wb. Next cycle accept addi x2,x1,-4 (0xFFC08113) -> one cycle later: valid_out=1, opcode 0010011, funct3 000, funct7 0, rd 2, rs1_value 0x10, mux_result 0xFFFFFFFC.
- Same cycle: wb x3=0xDEADBEEF and accept add x4,x3,x3 (0x00318233) -> rs1_value=mux_result=0xDEADBEEF (bypass). A wb to x0 followed by a read of x0 -> 0.
- Accept srai x5,x1,3 (0x4030D293) -> funct3 101, funct7 0100000, mux_result 0x00000003.
- Hold ex_ready_in=0 with bundle valid and a new instruction offered -> instr_ready_out=0, outputs unchanged for 3 cycles. Raise ex_ready_in -> new bundle next cycle.
- Accept opcode 0000011 -> illegal_out pulses 1 cycle, valid_out=0. Flush_in with a valid instruction offered -> valid_out=0 next cycle, instruction dropped. Reset asserted with valid_out=1 -> valid_out=0 next cycle.
